// File: rtl/spart_rx.sv
// SPART serial receiver: oversampled mid-bit sampler, optional parity, receive FIFO
// and sticky framing/parity/overrun flags, read through the IORW/IOADDR bus.
module spart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 4,
    parameter bit PARITY_EN  = 1'b0,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RxD,
    input  logic       Enable,
    input  logic       IORW,
    input  logic [1:0] IOADDR,
    output logic [7:0] DATA,
    output logic       RDA
);

    localparam int         AW        = $clog2(FIFO_DEPTH);
    localparam logic [3:0] HALF_TICK = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);
    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t                 state;
    logic                   rx_m, rx_s;
    logic [3:0]             tick_cnt;
    logic [2:0]             bit_idx;
    logic [DATA_BITS-1:0]   shreg;
    logic                   par_bit;
    logic                   framing_err, parity_err, overrun;
    logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
    logic [AW:0]            wr_ptr, rd_ptr;

    logic empty, full, pop, clr, stop_tick, par_bad;
    logic set_fe, set_pe, set_ov, push;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= RxD;
            rx_s <= rx_m;
        end
    end

    // Receive FSM; only moves on baud ticks
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            tick_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
        end else if (Enable) begin
            case (state)
                S_IDLE: begin
                    tick_cnt <= '0;
                    if (!rx_s) state <= S_START;
                end
                S_START: begin
                    if (tick_cnt == HALF_TICK) begin
                        tick_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= rx_s ? S_IDLE : S_DATA;
                    end else begin
                        tick_cnt <= tick_cnt + 4'd1;
                    end
                end
                S_DATA: begin
                    if (tick_cnt == LAST_TICK) begin
                        tick_cnt <= '0;
                        shreg    <= {rx_s, shreg[DATA_BITS-1:1]};
                        if (bit_idx == LAST_BIT) begin
                            bit_idx <= '0;
                            state   <= PARITY_EN ? S_PARITY : S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        tick_cnt <= tick_cnt + 4'd1;
                    end
                end
                S_PARITY: begin
                    if (tick_cnt == LAST_TICK) begin
                        tick_cnt <= '0;
                        par_bit  <= rx_s;
                        state    <= S_STOP;
                    end else begin
                        tick_cnt <= tick_cnt + 4'd1;
                    end
                end
                S_STOP: begin
                    if (tick_cnt == LAST_TICK) begin
                        tick_cnt <= '0;
                        state    <= S_IDLE;
                    end else begin
                        tick_cnt <= tick_cnt + 4'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign pop       = IORW && (IOADDR == 2'b00) && !empty;
    assign clr       = IORW && (IOADDR == 2'b01);
    assign stop_tick = Enable && (state == S_STOP) && (tick_cnt == LAST_TICK);
    assign par_bad   = PARITY_EN && (par_bit != ((^shreg) ^ PARITY_ODD));

    // Frame verdict in priority order: framing, parity, overrun, accept
    assign set_fe = stop_tick && !rx_s;
    assign set_pe = stop_tick && rx_s && par_bad;
    assign set_ov = stop_tick && rx_s && !par_bad && full && !pop;
    assign push   = stop_tick && rx_s && !par_bad && (!full || pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            framing_err <= 1'b0;
            parity_err  <= 1'b0;
            overrun     <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= shreg;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            framing_err <= set_fe | (framing_err & ~clr);
            parity_err  <= set_pe | (parity_err & ~clr);
            overrun     <= set_ov | (overrun & ~clr);
        end
    end

    assign RDA = !empty;

    always_comb begin
        DATA = 8'h00;
        case (IOADDR)
            2'b00:   DATA = 8'(mem[rd_ptr[AW-1:0]]);
            2'b01:   DATA = {4'b0000, overrun, parity_err, framing_err, RDA};
            default: DATA = 8'h00;
        endcase
    end

endmodule
